// File: rtl/huffman_pkg.sv
// Shared constants, types and the code table for the serial Huffman encoder/decoder pair.
// Codewords are stored left-aligned in MAX_LEN bits so the MSB is always the next bit to send.
package huffman_pkg;

    localparam int SYM_W   = 5;
    localparam int MAX_LEN = 8;
    localparam int NUM_SYM = 18;

    typedef logic [SYM_W-1:0]   sym_t;
    typedef logic [MAX_LEN-1:0] code_t;
    typedef logic [3:0]         len_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam code_t CODE [1:NUM_SYM] = '{
        8'b0000_0000, 8'b0100_0000, 8'b1000_0000, 8'b1100_0000,
        8'b1110_0000, 8'b1110_0100, 8'b1110_1000,
        8'b1110_1100, 8'b1110_1110,
        8'b1111_0000, 8'b1111_0010, 8'b1111_0100, 8'b1111_0110,
        8'b1111_1000, 8'b1111_1010, 8'b1111_1100,
        8'b1111_1110, 8'b1111_1111
    };

    localparam len_t LEN [1:NUM_SYM] = '{
        4'd2, 4'd2, 4'd2, 4'd3,
        4'd6, 4'd6, 4'd6,
        4'd7, 4'd7,
        4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7,
        4'd8, 4'd8
    };

endpackage

// File: rtl/huffman_encoder_if.sv
// Symbol-in / bit-out bundle of the encoder. Both sides use valid/ready: a transfer happens
// on a rising clk edge where valid and ready are both high; valid may not depend on ready.
interface huffman_encoder_if import huffman_pkg::*;;

    sym_t   sym;
    logic   sym_valid;
    logic   sym_ready;
    logic   out;
    logic   out_valid;
    logic   out_ready;
    logic   last;
    state_t dbg_state;

    modport master (
        output sym, sym_valid, out_ready,
        input  sym_ready, out, out_valid, last, dbg_state
    );

    modport slave (
        input  sym, sym_valid, out_ready,
        output sym_ready, out, out_valid, last, dbg_state
    );

endinterface

// File: rtl/huffman_code_rom.sv
// Combinational symbol -> (left-aligned code, length, valid) lookup.
// Symbols outside 1..NUM_SYM return valid=0 with zero code and length.
module huffman_code_rom import huffman_pkg::*; (
    input  sym_t  sym,
    output code_t code,
    output len_t  len,
    output logic  valid
);

    always_comb begin
        code  = '0;
        len   = '0;
        valid = 1'b0;
        for (int i = 1; i <= NUM_SYM; i++) begin
            if (sym == sym_t'(i)) begin
                code  = CODE[i];
                len   = LEN[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: one symbol in, its codeword out MSB first, one bit per transfer.
// Optional `err` pulse on invalid symbols is enabled by defining HUFF_ENC_ERR_EN.
module huffman_encoder import huffman_pkg::*; (
    input  logic clk,
    input  logic reset,
`ifdef HUFF_ENC_ERR_EN
    output logic err,
`endif
    huffman_encoder_if.slave bus
);

    state_t state, state_next;
    code_t  shreg, shreg_next;
    len_t   cnt, cnt_next;
    logic   out_valid_q, out_valid_next;
    logic   last_q, last_next;

    code_t  rom_code;
    len_t   rom_len;
    logic   rom_valid;

    logic   fire;
    logic   end_cw;
    logic   accept;
    logic   load;

    huffman_code_rom u_rom (
        .sym   (bus.sym),
        .code  (rom_code),
        .len   (rom_len),
        .valid (rom_valid)
    );

    assign fire   = out_valid_q & bus.out_ready;
    // Final bit leaving this cycle frees the encoder, so a new symbol can load with no bubble.
    assign end_cw = (state == SHIFT) && (cnt == len_t'(1)) && bus.out_ready;
    assign bus.sym_ready = (state == IDLE) || end_cw;
    assign accept = bus.sym_valid & bus.sym_ready;
    assign load   = accept & rom_valid;

    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        cnt_next       = cnt;
        out_valid_next = out_valid_q;
        last_next      = last_q;
        if (load) begin
            state_next     = SHIFT;
            shreg_next     = rom_code;
            cnt_next       = rom_len;
            out_valid_next = 1'b1;
            last_next      = (rom_len == len_t'(1));
        end else if (fire) begin
            shreg_next = {shreg[MAX_LEN-2:0], 1'b0};
            cnt_next   = cnt - len_t'(1);
            if (cnt == len_t'(1)) begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
                last_next      = 1'b0;
            end else begin
                last_next = (cnt == len_t'(2));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            cnt         <= cnt_next;
            out_valid_q <= out_valid_next;
            last_q      <= last_next;
        end
    end

    // Shifting in zeros leaves the register clear after a codeword, so `out` idles at 0.
    assign bus.out       = shreg[MAX_LEN-1];
    assign bus.out_valid = out_valid_q;
    assign bus.last      = last_q;
    assign bus.dbg_state = state;

`ifdef HUFF_ENC_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & ~rom_valid;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: doc/huffman_encoder.md
# huffman_encoder

Serial Huffman encoder that turns 5-bit symbol indices (1..18) into their fixed prefix-free codewords and emits them one bit per cycle, MSB first. It is the transmit-side counterpart of `huffman_decoder`: its `out` stream connects directly to the decoder's serial `in`, and the code table is identical. Symbols enter through a valid/ready handshake. Bits leave through a valid/ready handshake with a `last` marker on each codeword's final bit.

## Interface
- `SYM_W`, 5, symbol index width
- `MAX_LEN`, 8, longest codeword length in bits
- `clk` input 1 — single clock, rising edge
- `reset` input 1 — synchronous, active-low; sampled on `clk` rising edge
- `sym` input SYM_W — symbol index; valid codes are 1..18
- `sym_valid` input 1 — `sym` is presented
- `sym_ready` output 1 — encoder accepts `sym` this cycle
- `out` output 1 — current code bit
- `out_valid` output 1 — `out` is meaningful
- `out_ready` input 1 — sink consumes `out` this cycle
- `last` output 1 — `out` is the final bit of the codeword
- `err` output 1 — one-cycle pulse on an invalid symbol (present only with HUFF_ENC_ERR_EN)

## Operation
Code table (symbol: code):
- 1:00, 2:01, 3:10, 4:110
- 5:111000, 6:111001, 7:111010
- 8:1110110, 9:1110111
- 10:1111000 … 16:1111110, ascending binary
- 17:11111110, 18:11111111

State machine:
- States are IDLE and SHIFT.
- IDLE:
  - `sym_ready`=1.
  - On accepting a valid symbol: load the code, left-aligned, into an 8-bit shift register; load its length into a 4-bit remaining-bit counter; go to SHIFT.
- SHIFT:
  - `out` = shift register MSB; `out_valid`=1.
  - `last`=1 when the counter equals 1.
  - On `out_valid && out_ready`: shift left one bit and decrement the counter.
- End of codeword (transfer with `last`=1):
  - `sym_ready`=1 in that same cycle (combinational on `out_ready`).
  - If `sym_valid`, the next codeword loads and SHIFT continues with no bubble.
  - Otherwise the block returns to IDLE.
- In SHIFT with the counter above 1, `sym_ready`=0.

Invalid symbols (0, 19..31):
- Accepted (the handshake completes) and dropped.
- No bits are emitted and the state is unchanged.

Boundary conditions:
- Backpressure: while `out_ready`=0, `out`, `out_valid` and `last` hold their values; the counter does not change.
- Reset mid-codeword aborts it. Remaining bits are discarded and the block does not resume.
- An invalid symbol arriving at end-of-codeword ends the stream and the block returns to IDLE.

## Timing
- Reset values:
  - `out_valid`=0, `out`=0, `last`=0, `err`=0
  - state IDLE, so `sym_ready`=1 on the first cycle after reset release
- Latency: a symbol accepted at edge N drives its first bit at `out_valid` from edge N onward; it is consumed at edge N+1 at the earliest.
- Throughput: one bit per cycle with `out_ready` held high, including across codeword boundaries.
- A codeword of length L occupies exactly L transfer cycles.
- `out`, `out_valid` and `last` are register outputs.
- `sym_ready` is combinational from state, the counter and `out_ready`.

## Configuration
- `HUFF_ENC_ERR_EN` defined:
  - The `err` port exists.
  - An invalid symbol accepted at edge N gives `err`=1 for the cycle after edge N only.
  - `err` resets to 0.
- `HUFF_ENC_ERR_EN` undefined:
  - No `err` port.
  - Invalid symbols are dropped silently.
- The handshake is identical in both builds.

## Structure
- `huffman_pkg` holds:
  - `SYM_W`, `MAX_LEN`, `NUM_SYM`=18
  - typedefs `sym_t` (logic [4:0]), `code_t` (logic [7:0]), `len_t` (logic [3:0])
  - constant arrays `CODE[1:18]` (left-aligned) and `LEN[1:18]`
  - the state enum
- Sub-module `huffman_code_rom`: combinational `sym` → (`code`, `len`, `valid`). It is shared with the decoder's verification model.

## Test plan
- Reset, then `sym`=1 with `out_ready`=1:
  - `out` = 0, 0 on two consecutive cycles.
  - `last`=1 on the second only; `out_valid`=0 afterwards.
- `sym`=18:
  - Eight `out`=1 bits with `last` on the eighth.
  - `sym_ready`=0 for bits 1..7.
- Back-to-back `sym`=4 then `sym`=5, `sym_valid` held:
  - `out` = 1,1,0,1,1,1,0,0,0 over 9 contiguous cycles.
  - `last` on cycles 3 and 9.
- `sym`=10 with `out_ready`=0 for 3 cycles after the first bit:
  - `out`=1, `out_valid`=1 held for 4 cycles.
  - The full stream is still 1111000.
- `sym`=0 and `sym`=25:
  - Each is accepted and `out_valid` stays 0.
  - `err` pulses once each when HUFF_ENC_ERR_EN is defined.
- Reset asserted after 3 bits of `sym`=9:
  - `out_valid`=0 the next cycle.
  - Then `sym`=2 yields 0,1.
- Loopback into `huffman_decoder`, symbols 1..18 in random order: every decoded `sx` equals the sent symbol.
